// File: rtl/minkowski_support_ctrl.sv
// -----------------------------------------------------------------------------
// minkowski_support_ctrl
//
// Sequences two queries to a shared support-point unit to build one support
// point of the Minkowski difference A - B along a direction d:
//   1. query shape A along  d  -> support point sA
//   2. query shape B along -d  -> support point sB
//   3. publish mink = sA - sB with a one-cycle valid pulse
// Each wait for the support unit is guarded by a 15-cycle timeout that sets a
// sticky timeout_err and abandons the request without a valid pulse.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_start               request pulse, accepted only while idle
//   dir_x, dir_y            query direction d (signed 10-bit), latched on accept
//   a_verts, b_verts        four packed (x,y) 19-bit vertices per shape,
//                           vertex k at [38k+37:38k], x in the low half
//   a_pos, b_pos            shape position {y, x}, 19-bit signed each
//   sup_start               registered one-cycle start to the support unit
//   sup_verts, sup_pos      operand shape routed to the support unit
//   sup_dir_x, sup_dir_y    direction presented to the support unit
//   sup_best_x, sup_best_y  support point returned by the support unit
//   sup_done                support-unit completion level
//   busy                    high whenever the controller is not idle
//   mink_x, mink_y          Minkowski-difference support point (held)
//   valid                   one-cycle pulse marking mink_x/mink_y as new
//   timeout_err             sticky timeout flag, cleared on the next accept
// -----------------------------------------------------------------------------
module minkowski_support_ctrl (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_start,
    input  logic signed [9:0]   dir_x,
    input  logic signed [9:0]   dir_y,
    input  logic [151:0]        a_verts,
    input  logic [151:0]        b_verts,
    input  logic [37:0]         a_pos,
    input  logic [37:0]         b_pos,
    output logic                sup_start,
    output logic [151:0]        sup_verts,
    output logic [37:0]         sup_pos,
    output logic signed [9:0]   sup_dir_x,
    output logic signed [9:0]   sup_dir_y,
    input  logic signed [18:0]  sup_best_x,
    input  logic signed [18:0]  sup_best_y,
    input  logic                sup_done,
    output logic                busy,
    output logic signed [18:0]  mink_x,
    output logic signed [18:0]  mink_y,
    output logic                valid,
    output logic                timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_A  = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_REQ_B  = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_OUT    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Last wait-counter value before giving up: counts 0..14 = 15 wait cycles.
    localparam logic [3:0] WAIT_LAST = 4'd14;

    // Negate a direction component; -(-512) has no 10-bit representation and
    // saturates to +511 instead of wrapping back to -512.
    function automatic logic signed [9:0] neg_sat(input logic signed [9:0] v);
        logic signed [9:0] r;
        if (v == -10'sd512) begin
            r = 10'sd511;
        end else begin
            r = -v;
        end
        return r;
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [3:0]         wait_cnt_r;
    logic signed [9:0]  dir_x_r;
    logic signed [9:0]  dir_y_r;
    logic signed [9:0]  sup_dir_x_r;
    logic signed [9:0]  sup_dir_y_r;
    logic signed [18:0] a_x_r;
    logic signed [18:0] a_y_r;
    logic signed [18:0] b_x_r;
    logic signed [18:0] b_y_r;
    logic signed [18:0] mink_x_r;
    logic signed [18:0] mink_y_r;
    logic               sup_start_r;
    logic               busy_r;
    logic               valid_r;
    logic               timeout_err_r;

    logic               accept_s;
    logic               cap_a_s;
    logic               cap_b_s;
    logic               to_err_s;
    logic               enter_b_s;
    logic               wait_stay_s;
    logic [151:0]       sup_verts_s;
    logic [37:0]        sup_pos_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; done is ignored in the first cycle of each wait
    // (counter still zero) so a stale level from the previous query is not taken.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_start) begin
                    next_state_s = ST_REQ_A;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ_A: begin
                next_state_s = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if ((wait_cnt_r != 4'd0) && sup_done) begin
                    next_state_s = ST_REQ_B;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_WAIT_A;
                end
            end
            ST_REQ_B: begin
                next_state_s = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if ((wait_cnt_r != 4'd0) && sup_done) begin
                    next_state_s = ST_OUT;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_WAIT_B;
                end
            end
            ST_OUT: begin
                next_state_s = ST_IDLE;
            end
            ST_ERR: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output/strobe decode: operand routing follows the phase, and the
    // transition strobes drive the datapath registers below.
    always_comb begin
        sup_verts_s = 152'd0;
        sup_pos_s   = 38'd0;
        case (state_r)
            ST_REQ_A, ST_WAIT_A: begin
                sup_verts_s = a_verts;
                sup_pos_s   = a_pos;
            end
            ST_REQ_B, ST_WAIT_B: begin
                sup_verts_s = b_verts;
                sup_pos_s   = b_pos;
            end
            default: begin
                sup_verts_s = 152'd0;
                sup_pos_s   = 38'd0;
            end
        endcase
        accept_s    = (state_r == ST_IDLE)   && (next_state_s == ST_REQ_A);
        cap_a_s     = (state_r == ST_WAIT_A) && (next_state_s == ST_REQ_B);
        cap_b_s     = (state_r == ST_WAIT_B) && (next_state_s == ST_OUT);
        to_err_s    = (state_r != ST_ERR)    && (next_state_s == ST_ERR);
        enter_b_s   = (state_r != ST_REQ_B)  && (next_state_s == ST_REQ_B);
        wait_stay_s = ((state_r == ST_WAIT_A) || (state_r == ST_WAIT_B)) &&
                      (next_state_s == state_r);
    end

    // Wait-cycle counter: zero on entry to a wait state, counts while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 4'd0;
        end else if (wait_stay_s) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
        end else begin
            wait_cnt_r <= 4'd0;
        end
    end

    // Direction latch and the direction presented to the support unit;
    // the B query uses the negated latched direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_x_r     <= 10'sd0;
            dir_y_r     <= 10'sd0;
            sup_dir_x_r <= 10'sd0;
            sup_dir_y_r <= 10'sd0;
        end else if (accept_s) begin
            dir_x_r     <= dir_x;
            dir_y_r     <= dir_y;
            sup_dir_x_r <= dir_x;
            sup_dir_y_r <= dir_y;
        end else if (enter_b_s) begin
            sup_dir_x_r <= neg_sat(dir_x_r);
            sup_dir_y_r <= neg_sat(dir_y_r);
        end else begin
            sup_dir_x_r <= sup_dir_x_r;
            sup_dir_y_r <= sup_dir_y_r;
        end
    end

    // Capture of the two support points returned by the support unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_x_r <= 19'sd0;
            a_y_r <= 19'sd0;
            b_x_r <= 19'sd0;
            b_y_r <= 19'sd0;
        end else if (cap_a_s) begin
            a_x_r <= sup_best_x;
            a_y_r <= sup_best_y;
        end else if (cap_b_s) begin
            b_x_r <= sup_best_x;
            b_y_r <= sup_best_y;
        end else begin
            a_x_r <= a_x_r;
            a_y_r <= a_y_r;
        end
    end

    // Result register: A - B in 19-bit two's complement (wraps), held between OUTs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mink_x_r <= 19'sd0;
            mink_y_r <= 19'sd0;
        end else if (state_r == ST_OUT) begin
            mink_x_r <= a_x_r - b_x_r;
            mink_y_r <= a_y_r - b_y_r;
        end else begin
            mink_x_r <= mink_x_r;
            mink_y_r <= mink_y_r;
        end
    end

    // Control outputs registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sup_start_r <= 1'b0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else begin
            sup_start_r <= (next_state_s == ST_REQ_A) || (next_state_s == ST_REQ_B);
            busy_r      <= (next_state_s != ST_IDLE);
            valid_r     <= (state_r == ST_OUT);
        end
    end

    // Sticky timeout flag: set on entering ERR, cleared only by a new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_r <= 1'b0;
        end else if (accept_s) begin
            timeout_err_r <= 1'b0;
        end else if (to_err_s) begin
            timeout_err_r <= 1'b1;
        end else begin
            timeout_err_r <= timeout_err_r;
        end
    end

    assign sup_start   = sup_start_r;
    assign sup_verts   = sup_verts_s;
    assign sup_pos     = sup_pos_s;
    assign sup_dir_x   = sup_dir_x_r;
    assign sup_dir_y   = sup_dir_y_r;
    assign busy        = busy_r;
    assign mink_x      = mink_x_r;
    assign mink_y      = mink_y_r;
    assign valid       = valid_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_minkowski_support_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for minkowski_support_ctrl. A behavioural support unit
// answers each sup_start with the vertex maximising dot(v, d) (first vertex on
// ties) plus the shape position, raising sup_done a programmable number of
// edges later (0 = never). Expected results are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_minkowski_support_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                req_start;
    logic signed [9:0]   dir_x, dir_y;
    logic [151:0]        a_verts, b_verts;
    logic [37:0]         a_pos, b_pos;
    logic                sup_start;
    logic [151:0]        sup_verts;
    logic [37:0]         sup_pos;
    logic signed [9:0]   sup_dir_x, sup_dir_y;
    logic signed [18:0]  sup_best_x = 19'sd0;
    logic signed [18:0]  sup_best_y = 19'sd0;
    logic                sup_done = 1'b0;
    logic                busy;
    logic signed [18:0]  mink_x, mink_y;
    logic                valid;
    logic                timeout_err;

    minkowski_support_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_start(req_start),
        .dir_x(dir_x), .dir_y(dir_y),
        .a_verts(a_verts), .b_verts(b_verts), .a_pos(a_pos), .b_pos(b_pos),
        .sup_start(sup_start), .sup_verts(sup_verts), .sup_pos(sup_pos),
        .sup_dir_x(sup_dir_x), .sup_dir_y(sup_dir_y),
        .sup_best_x(sup_best_x), .sup_best_y(sup_best_y), .sup_done(sup_done),
        .busy(busy), .mink_x(mink_x), .mink_y(mink_y),
        .valid(valid), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Support-unit stub.
    int stub_delay = 3;
    int stub_cnt   = 0;
    int sb_best, sb_dot;
    logic signed [18:0] sb_x, sb_y, vx, vy;

    always @(posedge clk) begin
        if (sup_start) begin
            sb_best = 0;
            sb_x    = 19'sd0;
            sb_y    = 19'sd0;
            for (int k = 0; k < 4; k++) begin
                vx = $signed(sup_verts[38*k +: 19]);
                vy = $signed(sup_verts[38*k+19 +: 19]);
                sb_dot = int'(vx) * int'(sup_dir_x) + int'(vy) * int'(sup_dir_y);
                if (k == 0 || sb_dot > sb_best) begin
                    sb_best = sb_dot;
                    sb_x    = vx;
                    sb_y    = vy;
                end
            end
            sup_best_x <= sb_x + $signed(sup_pos[18:0]);
            sup_best_y <= sb_y + $signed(sup_pos[37:19]);
            sup_done   <= 1'b0;
            stub_cnt   <= stub_delay;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) sup_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [151:0] pack4(input int x0, input int y0, input int x1, input int y1,
                                           input int x2, input int y2, input int x3, input int y3);
        return {y3[18:0], x3[18:0], y2[18:0], x2[18:0], y1[18:0], x1[18:0], y0[18:0], x0[18:0]};
    endfunction

    function automatic logic [37:0] pack_pos(input int x, input int y);
        return {y[18:0], x[18:0]};
    endfunction

    // Observations of one request window (cycle 1 = cycle after acceptance edge).
    int r_vcyc, r_vcnt, r_nstart, r_tefirst, r_busylow;
    logic signed [9:0]  r_dirb;
    logic signed [18:0] r_mx, r_my;
    logic               r_te1;

    // Issue one request at a negedge and watch 24 cycles; optionally re-pulse
    // req_start during cycles 3 and 6 while busy.
    task automatic run_req(input logic signed [9:0] dx, input logic signed [9:0] dy, input bit extra);
        r_vcyc = 0; r_vcnt = 0; r_nstart = 0; r_tefirst = 0; r_busylow = 0;
        r_dirb = 10'sd0; r_mx = 19'sd0; r_my = 19'sd0; r_te1 = 1'b0;
        dir_x = dx; dir_y = dy; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 1) r_te1 = timeout_err;
            if (sup_start) begin
                r_nstart++;
                if (r_nstart == 2) r_dirb = sup_dir_x;
            end
            if (valid) begin
                r_vcnt++;
                if (r_vcyc == 0) begin
                    r_vcyc = c; r_mx = mink_x; r_my = mink_y;
                end
            end
            if (timeout_err && r_tefirst == 0) r_tefirst = c;
            if (!busy && r_busylow == 0) r_busylow = c;
            req_start = extra && (c == 2 || c == 5);
            @(negedge clk);
        end
        req_start = 1'b0;
    endtask

    int pv, ps;

    initial begin
        rst_n = 1'b0; req_start = 1'b0; dir_x = 10'sd0; dir_y = 10'sd0;
        a_verts = pack4(10, 10, -10, 10, -10, -10, 10, -10);
        b_verts = pack4(4, 4, -4, 4, -4, -4, 4, -4);
        a_pos   = pack_pos(0, 0);
        b_pos   = pack_pos(5, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sup_start", sup_start, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_mink_x", mink_x, 0);
        chk("rst_mink_y", mink_y, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Squares, d=(1,0): A support (10,10), B support (-4,4)+(5,0) -> mink (9,6).
        run_req(10'sd1, 10'sd0, 1'b0);
        chk("sq_valid_cycle", r_vcyc, 12);
        chk("sq_mink_x", r_mx, 9);
        chk("sq_mink_y", r_my, 6);
        chk("sq_valid_count", r_vcnt, 1);
        chk("sq_start_count", r_nstart, 2);
        chk("sq_busy_low_cycle", r_busylow, 12);

        // d=(-512,0): B direction saturates to +511; A (-10,10), B (4,4)+(5,0) -> (-19,6).
        run_req(-10'sd512, 10'sd0, 1'b0);
        chk("sat_dir_b", r_dirb, 511);
        chk("sat_mink_x", r_mx, -19);
        chk("sat_mink_y", r_my, 6);

        // Support unit never answers: timeout after 15 WAIT_A cycles.
        stub_delay = 0;
        run_req(10'sd1, 10'sd0, 1'b0);
        chk("to_valid_count", r_vcnt, 0);
        chk("to_flag_cycle", r_tefirst, 17);
        chk("to_busy_low_cycle", r_busylow, 18);
        chk("to_flag_sticky", timeout_err, 1);
        chk("to_mink_hold", mink_x, -19);

        // Recovery, d=(0,1): A (10,10), B (-4,-4)+(5,0) -> (9,14); flag cleared.
        stub_delay = 3;
        run_req(10'sd0, 10'sd1, 1'b0);
        chk("rec_flag_cleared", r_te1, 0);
        chk("rec_valid_count", r_vcnt, 1);
        chk("rec_mink_x", r_mx, 9);
        chk("rec_mink_y", r_my, 14);

        // Extra req_start pulses while busy are ignored.
        run_req(10'sd1, 10'sd0, 1'b1);
        chk("busy_req_valid_count", r_vcnt, 1);
        chk("busy_req_start_count", r_nstart, 2);
        chk("busy_req_valid_cycle", r_vcyc, 12);
        chk("busy_req_mink_x", r_mx, 9);

        // Reset asserted during WAIT_B (cycle 8) between clock edges.
        dir_x = 10'sd1; dir_y = 10'sd0; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("wb_busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_sup_start", sup_start, 0);
        chk("arst_valid", valid, 0);
        chk("arst_mink_x", mink_x, 0);
        chk("arst_mink_y", mink_y, 0);
        chk("arst_timeout", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pv = 0; ps = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid) pv++;
            if (sup_start) ps++;
        end
        chk("post_rst_valid", pv, 0);
        chk("post_rst_sup_start", ps, 0);

        // Wrap: 262143 - (-262144) = 524287 -> -1 in 19 bits.
        a_verts = pack4(262143, 0, 0, 0, 0, 0, 0, 0);
        b_verts = pack4(0, 0, -262144, 0, 0, 0, 0, 0);
        a_pos   = pack_pos(0, 0);
        b_pos   = pack_pos(0, 0);
        run_req(10'sd1, 10'sd0, 1'b0);
        chk("wrap_mink_x", r_mx, -1);
        chk("wrap_mink_y", r_my, 0);
        chk("wrap_valid_count", r_vcnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minkowski_support_ctrl.md
MINKOWSKI_SUPPORT_CTRL -- requirements
Module: minkowski_support_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req_start  input  1  request pulse; accepted only in IDLE.
REQ-005 dir_x, dir_y  input  10 each, signed  query direction d, sampled on acceptance.
REQ-006 a_verts, b_verts  input  152 each  four 19-bit signed (x,y) vertices per shape; vertex k occupies bits [38k+37:38k], with x in the low half.
REQ-007 a_pos, b_pos  input  38 each  shape position (x low, y high), 19-bit signed.
REQ-008 sup_start  output  1  registered start pulse to the support unit.
REQ-009 sup_verts, sup_pos  output  152, 38  operand shape presented to the support unit.
REQ-010 sup_dir_x, sup_dir_y  output  10 each, signed  direction presented to the support unit.
REQ-011 sup_best_x, sup_best_y  input  19 each, signed  support vertex returned.
REQ-012 sup_done  input  1  support-unit completion level.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mink_x, mink_y  output  19 each, signed  Minkowski-difference support point.
REQ-015 valid  output  1  one-cycle pulse marking mink_x/mink_y as new.
REQ-016 timeout_err  output  1  sticky flag; cleared only by reset or by accepting a new request.

Function
REQ-017 The FSM SHALL have the states IDLE, REQ_A, WAIT_A, REQ_B, WAIT_B and OUT, plus the flag state ERR.
REQ-018 IDLE: when req_start=1, the block SHALL latch dir_x/dir_y, clear timeout_err and move to REQ_A; otherwise it SHALL remain in IDLE.
REQ-019 REQ_A: sup_start=1 for exactly one cycle; sup_verts=a_verts, sup_pos=a_pos, sup_dir=latched d; next state WAIT_A.
REQ-020 WAIT_A: the block SHALL hold operands and ignore sup_done in the first WAIT cycle; on sup_done=1 it SHALL capture sup_best into an internal A register and move to REQ_B.
REQ-021 REQ_B / WAIT_B: as REQ_A/WAIT_A, but with b_verts, b_pos and direction -d; the B capture moves the FSM to OUT.
REQ-022 Negation rule: -(-512) SHALL saturate to +511; every other value is negated exactly.
REQ-023 OUT: the block SHALL register mink = A - B (19-bit two's complement, wrap on overflow), pulse valid=1 for one cycle, then return to IDLE.
REQ-024 sup_start SHALL be low in all states other than REQ_A and REQ_B.
REQ-025 Each WAIT state SHALL run a 4-bit cycle counter; if sup_done is not seen within 15 cycles, the block SHALL set timeout_err, skip valid and return to IDLE.
REQ-026 mink_x/mink_y SHALL hold their last value until the next OUT or reset.
REQ-027 req_start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-028 Latency: with a compliant support unit (done 4 edges after start deasserts), valid SHALL be high in the 12th cycle after the acceptance edge, and the next request is accepted on the following cycle.
REQ-029 Inputs a_*, b_* and dir SHALL be treated as stable only at their use point; dir is latched, and vertices/pos are passed through combinationally during REQ/WAIT.

Reset
REQ-030 While rst_n=0 the block SHALL hold: state=IDLE, sup_start=0, busy=0, valid=0, timeout_err=0, mink_x=mink_y=0, the internal A register=0, and the counters=0.
REQ-031 Assertion of rst_n mid-operation SHALL abort immediately; no valid pulse is produced for the aborted request.
REQ-032 Release of rst_n SHALL take effect synchronously to clk through the next edge, and no sup_start SHALL be issued until a new req_start.

Verification
REQ-033 Square A at (0,0) with vertices (+/-10,+/-10), square B at (5,0) with vertices (+/-4,+/-4) around pos, d=(1,0) -> valid at cycle 12 with mink=(10-1,.)=(9,*); check that the x component equals 9.
REQ-034 d=(-512,0) -> sup_dir_x observed =+511 during REQ_B; mink is consistent with the saturated direction.
REQ-035 Support-model stub that never raises sup_done -> timeout_err=1 after 15 WAIT_A cycles, no valid pulse, busy drops; a following request clears the flag.
REQ-036 req_start pulsed at cycles 3 and 6 after the first acceptance -> exactly one valid pulse and a single sup_start pair.
REQ-037 rst_n driven low during WAIT_B -> all outputs go to their reset values asynchronously; no valid pulse after release.
REQ-038 A vertex x=+262143 with B vertex x=-262144 -> mink_x wraps to -1.
